// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands and carry-in are captured on start. One bit pair is then added per
// clock, LSB first, with the carry held in a flop between cycles. The sum is
// assembled in a shift register and published, together with the carry-out,
// on the completion edge. Between completions sum/cout hold their last value.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               done_q,   done_d;

    // Full-adder cell fed by the LSBs of the operand shift registers.
    logic fa_p;
    logic fa_bit;
    logic fa_carry;

    // Single full-adder cell: propagate, sum bit and carry for the current bit pair.
    always_comb begin
        fa_p     = a_sr_q[0] ^ b_sr_q[0];
        fa_bit   = fa_p ^ carry_q;
        fa_carry = (a_sr_q[0] & b_sr_q[0]) | (fa_p & carry_q);
    end

    // Next-state and datapath control for IDLE/RUN.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d  = fa_carry;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {fa_bit, sum_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish directly from the shifted value so intermediate
                    // partial sums never appear on the sum output.
                    sum_d   = {fa_bit, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of the others; the comb block above
        // uses blocking assignments because it describes wires, not storage.
        if (!rst_n) begin
            // NOTE: every register is cleared here, including the shift
            // registers, so a mid-operation reset leaves no stale operand bits.
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

    // Outputs: busy follows the state so it drops asynchronously with reset.
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
    end

endmodule
